// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: controller state encoding, forwarding selects and
// the register-match helper used by both hazard and forwarding decode.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_FREEZE     = 2'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // True when a producer destination feeds a consumer source; $0 is hardwired
    // to zero, so it never counts as a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register addresses and flags
// in, pipeline register enables, flushes and forwarding selects out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_branch_taken;
    logic             mem_busy;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             memwb_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_branch_taken, mem_busy,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_branch_taken, mem_busy,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one EX operand: the younger EX/MEM producer beats the
// older MEM/WB producer; otherwise the register file value is used.
module fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output fwd_sel_t         sel
);

    // Pick the nearest in-flight producer of the operand.
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && reg_match(mem_rd, ex_src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && reg_match(wb_rd, ex_src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: same-cycle stall/flush/freeze
// decode, operand forwarding, event counters and a memory freeze watchdog.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
)(
    input  logic                 clock,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 timeout_err
);

    // One spare code above TIMEOUT so the incremented value never wraps.
    localparam int FRZ_W = $clog2(TIMEOUT + 2);

    hz_state_t        state_r, state_next_s;
    logic             load_use_s, stall_evt_s, flush_evt_s;
    logic             pc_we_s, ifid_we_s, idex_we_s, exmem_we_s, memwb_we_s;
    logic             ifid_flush_s, idex_flush_s, exmem_flush_s;
    logic [REG_W-1:0] ex_rs_r, ex_rt_r, wb_rd_r;
    logic             wb_regwrite_r;
    fwd_sel_t         fwd_a_s, fwd_b_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic [FRZ_W-1:0] freeze_cnt_r, freeze_inc_s;
    logic             timeout_err_r;

    assign load_use_s = hz.ex_memread && hz.ex_regwrite &&
                        ((hz.id_use_rs && reg_match(hz.ex_rd, hz.id_rs)) ||
                         (hz.id_use_rt && reg_match(hz.ex_rd, hz.id_rt)));
    assign freeze_inc_s = freeze_cnt_r + FRZ_W'(1);

    fwd_select u_fwd_a (
        .ex_src(ex_rs_r), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
        .wb_rd(wb_rd_r), .wb_regwrite(wb_regwrite_r), .sel(fwd_a_s)
    );
    fwd_select u_fwd_b (
        .ex_src(ex_rt_r), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
        .wb_rd(wb_rd_r), .wb_regwrite(wb_regwrite_r), .sel(fwd_b_s)
    );

    // Prioritised hazard decode (busy > branch > load-use) and next-state class.
    always_comb begin
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        idex_we_s     = 1'b1;
        exmem_we_s    = 1'b1;
        memwb_we_s    = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        stall_evt_s   = 1'b0;
        flush_evt_s   = 1'b0;
        state_next_s  = ST_RUN;
        hz.fwd_a      = fwd_a_s;
        hz.fwd_b      = fwd_b_s;
        if (reset) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            hz.fwd_a      = FWD_RF;
            hz.fwd_b      = FWD_RF;
        end else if (hz.mem_busy) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_we_s    = 1'b0;
            exmem_we_s   = 1'b0;
            memwb_we_s   = 1'b0;
            state_next_s = ST_FREEZE;
        end else if (hz.mem_branch_taken) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            flush_evt_s   = 1'b1;
            state_next_s  = ST_FLUSH;
        end else if (load_use_s) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
            stall_evt_s  = 1'b1;
            state_next_s = ST_LOAD_STALL;
        end else begin
            state_next_s = ST_RUN;
        end
    end

    assign hz.pc_we       = pc_we_s;
    assign hz.ifid_we     = ifid_we_s;
    assign hz.idex_we     = idex_we_s;
    assign hz.exmem_we    = exmem_we_s;
    assign hz.memwb_we    = memwb_we_s;
    assign hz.ifid_flush  = ifid_flush_s;
    assign hz.idex_flush  = idex_flush_s;
    assign hz.exmem_flush = exmem_flush_s;

    // Record which event class occurred last cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow of the EX operand addresses, following the ID/EX register.
    always_ff @(posedge clock) begin
        if (reset || idex_flush_s) begin
            ex_rs_r <= 5'd0;
            ex_rt_r <= 5'd0;
        end else if (idex_we_s) begin
            ex_rs_r <= hz.id_rs;
            ex_rt_r <= hz.id_rt;
        end else begin
            ex_rs_r <= ex_rs_r;
            ex_rt_r <= ex_rt_r;
        end
    end

    // Shadow of the MEM/WB destination, following the MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_rd_r       <= 5'd0;
            wb_regwrite_r <= 1'b0;
        end else if (memwb_we_s) begin
            wb_rd_r       <= hz.mem_rd;
            wb_regwrite_r <= hz.mem_regwrite;
        end else begin
            wb_rd_r       <= wb_rd_r;
            wb_regwrite_r <= wb_regwrite_r;
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Watchdog on consecutive busy cycles; the error flag is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            freeze_cnt_r  <= {FRZ_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else if (hz.mem_busy) begin
            if (freeze_cnt_r < FRZ_W'(TIMEOUT)) begin
                freeze_cnt_r <= freeze_inc_s;
            end else begin
                freeze_cnt_r <= freeze_cnt_r;
            end
            if (freeze_inc_s >= FRZ_W'(TIMEOUT)) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end else begin
            freeze_cnt_r  <= {FRZ_W{1'b0}};
            timeout_err_r <= timeout_err_r;
        end
    end

    assign state       = state_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;
    assign timeout_err = timeout_err_r;

endmodule
